// File: rtl/err_compute_seq_pkg.sv
// Shared types and legality limits for the IR error-term sequencer.
// Holds the FSM state enum and the parameter range limits.
package err_compute_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DONE
    } err_seq_state_t;

    localparam int MAX_TERMS  = 256;
    localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/err_compute_seq_if.sv
// Handshake bundle between the IR front end and the error sequencer.
// master: drives IR_vld/abort; slave: drives sel and accumulator controls.
interface err_compute_seq_if #(
    parameter int SEL_W = 3
);
    logic             IR_vld;
    logic             abort;
    logic [SEL_W-1:0] sel;
    logic             clr_accum;
    logic             en_accum;
    logic             err_vld;
    logic             busy;
    logic             overrun;

    modport master (
        output IR_vld, abort,
        input  sel, clr_accum, en_accum, err_vld, busy, overrun
    );

    modport slave (
        input  IR_vld, abort,
        output sel, clr_accum, en_accum, err_vld, busy, overrun
    );
endinterface

// File: rtl/err_compute_seq_seq_counter.sv
// Up-counter with async reset; clr_i has priority over en_i.
// Ports: clk, rst_n, clr_i, en_i, q_o (count value).
module seq_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i)
            q_d = '0;
        else if (en_i)
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/err_compute_seq.sv
// Sequencer stepping the IR error-term mux and accumulator per sample set.
// Ports: clk, rst_n, bus (slave: IR_vld/abort in; sel/clr/en/err/busy/ovr out).
module err_compute_seq
    import err_compute_pkg::*;
#(
    parameter int NUM_TERMS  = 8,
    parameter int SETTLE     = 0,
    parameter int RESTART_EN = 1
) (
    input logic              clk,
    input logic              rst_n,
    err_compute_seq_if.slave bus
);
    localparam int SEL_B = $clog2(NUM_TERMS);
    localparam int SEL_W = (SEL_B < 1) ? 1 : SEL_B;
    localparam int CNT_B = $clog2(SETTLE + 1);
    localparam int CNT_W = (CNT_B < 1) ? 1 : CNT_B;
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam bit RESTART = (RESTART_EN != 0);
    // Entry state of every term: wait first if a settle delay is configured.
    localparam err_seq_state_t FIRST =
        (SETTLE > 0) ? err_compute_pkg::SETTLE : ACCUM;

    if (NUM_TERMS < 2 || NUM_TERMS > MAX_TERMS) begin : g_bad_terms
        $error("err_compute_seq: NUM_TERMS out of range 2..256");
    end
    if (SETTLE < 0 || SETTLE > MAX_SETTLE) begin : g_bad_settle
        $error("err_compute_seq: SETTLE out of range 0..15");
    end

    err_seq_state_t   state_q, state_d;
    logic [SEL_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             idx_clr, idx_en, cnt_clr, cnt_en;
    logic             restart;

    assign restart = bus.IR_vld && RESTART;

    seq_counter #(.W(SEL_W)) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (idx_clr),
        .en_i  (idx_en),
        .q_o   (idx_q)
    );

    seq_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .q_o   (cnt_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        idx_clr = 1'b0;
        idx_en  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            idx_clr = 1'b1;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.IR_vld) begin
                        state_d = FIRST;
                        idx_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                err_compute_pkg::SETTLE: begin
                    if (restart) begin
                        state_d = FIRST;
                        idx_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (cnt_q == CNT_LAST)
                            state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (restart) begin
                        state_d = FIRST;
                        idx_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = FIRST;
                        idx_en  = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                DONE: begin
                    // IR_vld here is a legal back-to-back start.
                    state_d = bus.IR_vld ? FIRST : IDLE;
                    idx_clr = 1'b1;
                    cnt_clr = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    idx_clr = 1'b1;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Pulses are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        bus.clr_accum = 1'b0;
        bus.en_accum  = 1'b0;
        bus.err_vld   = 1'b0;
        bus.overrun   = 1'b0;
        if (rst_n && !bus.abort) begin
            unique case (state_q)
                IDLE: begin
                    bus.clr_accum = bus.IR_vld;
                end
                err_compute_pkg::SETTLE: begin
                    bus.overrun   = bus.IR_vld;
                    bus.clr_accum = restart;
                end
                ACCUM: begin
                    bus.overrun   = bus.IR_vld;
                    bus.clr_accum = restart;
                    bus.en_accum  = !restart;
                end
                DONE: begin
                    bus.err_vld   = 1'b1;
                    bus.clr_accum = bus.IR_vld;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.sel  = idx_q;
endmodule
